dram_axi_burst_master: RTL and testbench

//  Parametrised successor of the single-beat DRAM AXI bridge. Converts the core-side request interface
//  (i_rd_en/i_wr_en/i_addr) into AXI4 INCR bursts of 1..MAX_BURST beats toward the MIG AXI slave.

---
 rtl/dram_axi_burst_master_if.sv | 80 ++++++++
 rtl/dram_axi_burst_master.sv | 191 +++++++++++++++++++
 tb/tb_dram_axi_burst_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_axi_burst_master_if.sv
// AXI4 bus between dram_axi_burst_master and the MIG s_axi slave port.
// Channel signal names follow the MIG s_axi_* naming so the wiring at the top level is obvious.
interface dram_axi_burst_master_if #(
    parameter int AW  = 29,
    parameter int DW  = 128,
    parameter int MW  = 16,
    parameter int IDW = 4
);
    logic [IDW-1:0] s_axi_awid;
    logic [AW-1:0]  s_axi_awaddr;
    logic [7:0]     s_axi_awlen;
    logic [2:0]     s_axi_awsize;
    logic [1:0]     s_axi_awburst;
    logic           s_axi_awlock;
    logic [3:0]     s_axi_awcache;
    logic [2:0]     s_axi_awprot;
    logic [3:0]     s_axi_awqos;
    logic           s_axi_awvalid;
    logic           s_axi_awready;

    logic [DW-1:0]  s_axi_wdata;
    logic [MW-1:0]  s_axi_wstrb;
    logic           s_axi_wlast;
    logic           s_axi_wvalid;
    logic           s_axi_wready;

    logic [IDW-1:0] s_axi_bid;
    logic [1:0]     s_axi_bresp;
    logic           s_axi_bvalid;
    logic           s_axi_bready;

    logic [IDW-1:0] s_axi_arid;
    logic [AW-1:0]  s_axi_araddr;
    logic [7:0]     s_axi_arlen;
    logic [2:0]     s_axi_arsize;
    logic [1:0]     s_axi_arburst;
    logic           s_axi_arlock;
    logic [3:0]     s_axi_arcache;
    logic [2:0]     s_axi_arprot;
    logic [3:0]     s_axi_arqos;
    logic           s_axi_arvalid;
    logic           s_axi_arready;

    logic [IDW-1:0] s_axi_rid;
    logic [DW-1:0]  s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rlast;
    logic           s_axi_rvalid;
    logic           s_axi_rready;

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
               s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
               s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface

// File: rtl/dram_axi_burst_master.sv
// Core-side request port to AXI4 INCR burst master (1..MAX_BURST beats) toward the MIG s_axi slave.
// Optional DRAM_AXI_RD_BACKPRESSURE_EN: read beats are accepted only while i_rd_ready is high.
module dram_axi_burst_master #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int ADDR_LSB       = 1,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_BURST      = 16
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic                      init_calib_complete,
    output logic                      o_init_calib_complete,
    input  logic                      i_rd_en,
    input  logic                      i_wr_en,
    input  logic [APP_ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]                i_len,
    output logic                      o_ready,
    input  logic [APP_DATA_WIDTH-1:0] i_wdata,
    input  logic [APP_MASK_WIDTH-1:0] i_mask,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    output logic [APP_DATA_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic                      o_data_last,
    input  logic                      i_rd_ready,
    output logic                      o_wr_done,
    output logic                      o_err,
    dram_axi_burst_master_if.master   axi
);
    localparam int AXI_AW = APP_ADDR_WIDTH + ADDR_LSB;
    localparam logic [7:0] LEN_MAX = 8'(MAX_BURST - 1);
    localparam logic [2:0] AXI_SIZE = 3'($clog2(APP_MASK_WIDTH));

    typedef enum logic [2:0] {
        CALIB, IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
    } state_t;

    state_t                    r_state, w_next;
    logic [APP_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [7:0]                r_beat;
    logic                      r_rd_err;
    logic                      r_wr_done;
    logic                      r_err;

    logic [AXI_AW-1:0] w_axi_addr;
    logic [7:0]        w_len;
    logic              w_ready;
    logic              w_awvalid, w_arvalid;
    logic              w_wvalid, w_wlast, w_wready_out;
    logic              w_bready, w_rready;
    logic              w_w_hs, w_b_hs, w_r_hs;
    logic              w_rd_bad;
    logic              w_unused;

    // Out-of-range lengths are illegal input; clamp so the beat counter can never run away.
    assign w_len      = (i_len > LEN_MAX) ? LEN_MAX : i_len;
    assign w_axi_addr = AXI_AW'(r_addr) << ADDR_LSB;

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_awvalid    = 1'b0;
        w_arvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_wlast      = 1'b0;
        w_wready_out = 1'b0;
        w_bready     = 1'b0;
        w_rready     = 1'b0;
        w_w_hs       = 1'b0;
        w_b_hs       = 1'b0;
        w_r_hs       = 1'b0;
        unique case (r_state)
            CALIB: begin
                if (init_calib_complete) w_next = IDLE;
            end
            IDLE: begin
                w_ready = 1'b1;
                if (i_wr_en)      w_next = WR_ADDR;
                else if (i_rd_en) w_next = RD_ADDR;
            end
            WR_ADDR: begin
                w_awvalid = 1'b1;
                if (axi.s_axi_awready) w_next = WR_DATA;
            end
            WR_DATA: begin
                w_wvalid     = i_wvalid;
                w_wready_out = axi.s_axi_wready;
                w_wlast      = (r_beat == r_len);
                w_w_hs       = i_wvalid & axi.s_axi_wready;
                if (w_w_hs && w_wlast) w_next = WR_RESP;
            end
            WR_RESP: begin
                w_bready = 1'b1;
                w_b_hs   = axi.s_axi_bvalid;
                if (w_b_hs) w_next = IDLE;
            end
            RD_ADDR: begin
                w_arvalid = 1'b1;
                if (axi.s_axi_arready) w_next = RD_DATA;
            end
            RD_DATA: begin
`ifdef DRAM_AXI_RD_BACKPRESSURE_EN
                w_rready = i_rd_ready;
`else
                w_rready = 1'b1;
`endif
                w_r_hs = axi.s_axi_rvalid & w_rready;
                if (w_r_hs && axi.s_axi_rlast) w_next = IDLE;
            end
            default: w_next = CALIB;
        endcase
    end

    // Early or late RLAST, or any non-OKAY beat, is reported once when the burst closes.
    assign w_rd_bad = r_rd_err | (axi.s_axi_rresp != 2'b00) | (r_beat != r_len);

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_state   <= CALIB;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_rd_err  <= 1'b0;
            r_wr_done <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wr_done <= w_b_hs;
            r_err     <= (w_b_hs && axi.s_axi_bresp != 2'b00) ||
                         (w_r_hs && axi.s_axi_rlast && w_rd_bad);
            if (r_state == IDLE) begin
                r_beat   <= '0;
                r_rd_err <= 1'b0;
                if (i_wr_en || i_rd_en) begin
                    r_addr <= i_addr;
                    r_len  <= w_len;
                end
            end else begin
                if (w_w_hs || w_r_hs) r_beat <= r_beat + 8'd1;
                if (w_r_hs && axi.s_axi_rresp != 2'b00) r_rd_err <= 1'b1;
            end
        end
    end

    assign o_init_calib_complete = init_calib_complete;
    assign o_ready      = w_ready;
    assign o_wready     = w_wready_out;
    assign o_data       = axi.s_axi_rdata;
    assign o_data_valid = w_r_hs;
    assign o_data_last  = w_r_hs & axi.s_axi_rlast;
    assign o_wr_done    = r_wr_done;
    assign o_err        = r_err;

    assign axi.s_axi_awid    = {AXI_ID_WIDTH{1'b0}};
    assign axi.s_axi_awaddr  = w_axi_addr;
    assign axi.s_axi_awlen   = r_len;
    assign axi.s_axi_awsize  = AXI_SIZE;
    assign axi.s_axi_awburst = 2'b01;
    assign axi.s_axi_awlock  = 1'b0;
    assign axi.s_axi_awcache = 4'd0;
    assign axi.s_axi_awprot  = 3'd0;
    assign axi.s_axi_awqos   = 4'd0;
    assign axi.s_axi_awvalid = w_awvalid;

    assign axi.s_axi_wdata   = i_wdata;
    assign axi.s_axi_wstrb   = ~i_mask;
    assign axi.s_axi_wlast   = w_wlast;
    assign axi.s_axi_wvalid  = w_wvalid;
    assign axi.s_axi_bready  = w_bready;

    assign axi.s_axi_arid    = {AXI_ID_WIDTH{1'b0}};
    assign axi.s_axi_araddr  = w_axi_addr;
    assign axi.s_axi_arlen   = r_len;
    assign axi.s_axi_arsize  = AXI_SIZE;
    assign axi.s_axi_arburst = 2'b01;
    assign axi.s_axi_arlock  = 1'b0;
    assign axi.s_axi_arcache = 4'd0;
    assign axi.s_axi_arprot  = 3'd0;
    assign axi.s_axi_arqos   = 4'd0;
    assign axi.s_axi_arvalid = w_arvalid;
    assign axi.s_axi_rready  = w_rready;

`ifdef DRAM_AXI_RD_BACKPRESSURE_EN
    assign w_unused = ^{axi.s_axi_bid, axi.s_axi_rid};
`else
    assign w_unused = ^{axi.s_axi_bid, axi.s_axi_rid, i_rd_ready};
`endif
endmodule

// File: tb/tb_dram_axi_burst_master.sv
// Directed bench for dram_axi_burst_master: calibration gating, write/read bursts, error paths,
// request priority with AW stall, and reset mid-burst. Works with or without DRAM_AXI_RD_BACKPRESSURE_EN.
module tb_dram_axi_burst_master;
    logic         ui_clk, ui_rst, init_calib_complete, o_init_calib_complete;
    logic         i_rd_en, i_wr_en;
    logic [27:0]  i_addr;
    logic [7:0]   i_len;
    logic         o_ready;
    logic [127:0] i_wdata;
    logic [15:0]  i_mask;
    logic         i_wvalid, o_wready;
    logic [127:0] o_data;
    logic         o_data_valid, o_data_last, i_rd_ready, o_wr_done, o_err;

    int n_tests = 0;
    int n_fail  = 0;

    dram_axi_burst_master_if #(.AW(29), .DW(128), .MW(16), .IDW(4)) axi ();

    dram_axi_burst_master dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst), .init_calib_complete(init_calib_complete),
        .o_init_calib_complete(o_init_calib_complete),
        .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_addr(i_addr), .i_len(i_len), .o_ready(o_ready),
        .i_wdata(i_wdata), .i_mask(i_mask), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_data(o_data), .o_data_valid(o_data_valid), .o_data_last(o_data_last),
        .i_rd_ready(i_rd_ready), .o_wr_done(o_wr_done), .o_err(o_err), .axi(axi)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic wr_burst(input string t, input logic [27:0] a, input logic [7:0] len,
                            input logic [1:0] bresp, input int aw_stall, input logic also_rd);
        logic [28:0] ea;
        logic [15:0] wl;
        int bad;
        ea = {a, 1'b0};
        i_wr_en = 1'b1; i_rd_en = also_rd; i_addr = a; i_len = len;
        tick();
        i_wr_en = 1'b0; i_rd_en = 1'b0; i_addr = '1; i_len = 8'd0;
        chk({t, "_awvalid"}, axi.s_axi_awvalid, 1'b1);
        chk({t, "_arvalid"}, axi.s_axi_arvalid, 1'b0);
        chk({t, "_awaddr"},  axi.s_axi_awaddr, ea);
        chk({t, "_awlen"},   axi.s_axi_awlen, len);
        chk({t, "_awsize_burst"}, {axi.s_axi_awsize, axi.s_axi_awburst}, {3'd4, 2'b01});
        chk({t, "_busy"},    o_ready, 1'b0);
        bad = 0;
        for (int i = 0; i < aw_stall; i++) begin
            tick();
            if (!axi.s_axi_awvalid || axi.s_axi_awaddr !== ea || axi.s_axi_awlen !== len) bad++;
            if (axi.s_axi_arvalid) bad++;
        end
        chk({t, "_aw_stable"}, bad, 0);
        axi.s_axi_awready = 1'b1;
        tick();
        axi.s_axi_awready = 1'b0;
        chk({t, "_aw_drop"}, axi.s_axi_awvalid, 1'b0);
        axi.s_axi_wready = 1'b1; i_wvalid = 1'b1; i_mask = 16'h0;
        bad = 0; wl = '0;
        for (int k = 0; k <= int'(len); k++) begin
            i_wdata = 128'hA + 128'(k);
            #1;
            if (!axi.s_axi_wvalid || !o_wready || axi.s_axi_wdata !== 128'hA + 128'(k)) bad++;
            if (axi.s_axi_wstrb !== 16'hFFFF) bad++;
            wl[k] = axi.s_axi_wlast;
            tick();
        end
        i_wvalid = 1'b0; axi.s_axi_wready = 1'b0;
        chk({t, "_wbeats"}, bad, 0);
        chk({t, "_wlast"}, wl, 16'(1) << len);
        chk({t, "_bready"}, {axi.s_axi_bready, axi.s_axi_wvalid}, 2'b10);
        axi.s_axi_bvalid = 1'b1; axi.s_axi_bresp = bresp;
        tick();
        axi.s_axi_bvalid = 1'b0; axi.s_axi_bresp = 2'b00;
        chk({t, "_wr_done"}, o_wr_done, 1'b1);
        chk({t, "_werr"}, o_err, bresp != 2'b00);
        chk({t, "_ready"}, o_ready, 1'b1);
        tick();
        chk({t, "_done_pulse"}, {o_wr_done, o_err}, 2'b00);
    endtask

    task automatic rd_burst(input string t, input logic [27:0] a, input logic [7:0] len,
                            input int rlast_at, input int err_beat);
        int bad;
        logic [15:0] dl;
        logic exp_err;
        i_rd_en = 1'b1; i_addr = a; i_len = len;
        tick();
        i_rd_en = 1'b0; i_addr = '1; i_len = 8'd0;
        chk({t, "_arvalid"}, {axi.s_axi_arvalid, axi.s_axi_awvalid}, 2'b10);
        chk({t, "_araddr"},  axi.s_axi_araddr, {a, 1'b0});
        chk({t, "_arlen"},   axi.s_axi_arlen, len);
        axi.s_axi_arready = 1'b1;
        tick();
        axi.s_axi_arready = 1'b0;
        chk({t, "_ar_drop"}, axi.s_axi_arvalid, 1'b0);
        i_rd_ready = 1'b0;
        #1;
`ifdef DRAM_AXI_RD_BACKPRESSURE_EN
        chk({t, "_rready_bp"}, axi.s_axi_rready, 1'b0);
`else
        chk({t, "_rready_bp"}, axi.s_axi_rready, 1'b1);
`endif
        i_rd_ready = 1'b1;
        #1;
        chk({t, "_rready"}, axi.s_axi_rready, 1'b1);
        bad = 0; dl = '0;
        for (int k = 0; k <= rlast_at; k++) begin
            axi.s_axi_rvalid = 1'b1;
            axi.s_axi_rdata  = 128'hA + 128'(k);
            axi.s_axi_rlast  = (k == rlast_at);
            axi.s_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            #1;
            if (!o_data_valid || o_data !== 128'hA + 128'(k)) bad++;
            dl[k] = o_data_last;
            tick();
        end
        axi.s_axi_rvalid = 1'b0; axi.s_axi_rlast = 1'b0; axi.s_axi_rresp = 2'b00;
        exp_err = (rlast_at != int'(len)) || (err_beat >= 0 && err_beat <= rlast_at);
        chk({t, "_rbeats"}, bad, 0);
        chk({t, "_rlast"}, dl, 16'(1) << rlast_at);
        chk({t, "_rerr"}, o_err, exp_err);
        chk({t, "_ready"}, o_ready, 1'b1);
        tick();
        chk({t, "_err_pulse"}, o_err, 1'b0);
    endtask

    initial begin
        int bad;
        ui_rst = 1'b1; init_calib_complete = 1'b0;
        i_rd_en = 1'b0; i_wr_en = 1'b0; i_addr = '0; i_len = '0;
        i_wdata = '0; i_mask = '0; i_wvalid = 1'b0; i_rd_ready = 1'b1;
        axi.s_axi_awready = 1'b0; axi.s_axi_wready = 1'b0;
        axi.s_axi_bid = '0; axi.s_axi_bresp = 2'b00; axi.s_axi_bvalid = 1'b0;
        axi.s_axi_arready = 1'b0; axi.s_axi_rid = '0; axi.s_axi_rdata = '0;
        axi.s_axi_rresp = 2'b00; axi.s_axi_rlast = 1'b0; axi.s_axi_rvalid = 1'b0;
        tick(); tick();
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_valids", {axi.s_axi_awvalid, axi.s_axi_arvalid, axi.s_axi_wvalid,
                           axi.s_axi_bready, axi.s_axi_rready, axi.s_axi_wlast}, 6'b0);
        chk("rst_pulses", {o_wr_done, o_err, o_wready, o_data_valid}, 4'b0);

        // calibration gating
        ui_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            i_wr_en = (i == 10);
            tick();
            if (o_ready || axi.s_axi_awvalid) bad++;
        end
        i_wr_en = 1'b0;
        chk("calib_hold", bad, 0);
        chk("calib_pass_lo", o_init_calib_complete, 1'b0);
        init_calib_complete = 1'b1;
        #1;
        chk("calib_edge", o_ready, 1'b0);
        chk("calib_pass_hi", o_init_calib_complete, 1'b1);
        tick();
        chk("calib_ready", o_ready, 1'b1);
        init_calib_complete = 1'b0;
        tick();
        chk("calib_sticky", o_ready, 1'b1);
        init_calib_complete = 1'b1;

        wr_burst("wr4", 28'h10, 8'd3, 2'b00, 0, 1'b0);
        rd_burst("rd4", 28'h10, 8'd3, 3, -1);
        wr_burst("wr_slverr", 28'h40, 8'd1, 2'b10, 0, 1'b0);
        rd_burst("rd_early", 28'h80, 8'd3, 1, -1);
        rd_burst("rd_rresp", 28'h90, 8'd1, 1, 0);
        wr_burst("wr_prio", 28'h123, 8'd2, 2'b00, 20, 1'b1);
        chk("prio_no_rd", axi.s_axi_arvalid, 1'b0);

        // reset while the second write beat is on the bus
        i_wr_en = 1'b1; i_addr = 28'h200; i_len = 8'd3;
        tick();
        i_wr_en = 1'b0;
        axi.s_axi_awready = 1'b1;
        tick();
        axi.s_axi_awready = 1'b0;
        axi.s_axi_wready = 1'b1; i_wvalid = 1'b1; i_wdata = 128'hA;
        tick();
        i_wdata = 128'hB;
        #1;
        chk("rst_mid_pre", axi.s_axi_wvalid, 1'b1);
        ui_rst = 1'b1;
        tick();
        chk("rst_mid_wvalid", {axi.s_axi_wvalid, axi.s_axi_awvalid, axi.s_axi_wlast}, 3'b000);
        chk("rst_mid_ready", o_ready, 1'b0);
        ui_rst = 1'b0; i_wvalid = 1'b0; axi.s_axi_wready = 1'b0;
        tick();
        chk("rst_mid_recover", o_ready, 1'b1);

        wr_burst("wr1", 28'h300, 8'd0, 2'b00, 0, 1'b0);
        rd_burst("rd1", 28'h300, 8'd0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
